// File: rtl/stream_sched_pkg.sv
// stream_sched_pkg
// Shared types and constants for the stream scheduler.
//   chan_state_t : per-channel transfer state
//   DIR_IN/DIR_OUT : encoding of cfg_dir
//   chan_sel_t   : channel index for the default channel count
package stream_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN_IN  = 2'd1,
    RUN_OUT = 2'd2,
    HOLD    = 2'd3
  } chan_state_t;

  localparam logic DIR_IN  = 1'b0;
  localparam logic DIR_OUT = 1'b1;

  localparam int SCHED_CHANNELS = 4;
  localparam int CHAN_SEL_W     = $clog2(SCHED_CHANNELS);

  typedef logic [CHAN_SEL_W-1:0] chan_sel_t;

endpackage

// File: rtl/stream_scheduler_arbiter.sv
// stream_rr_arbiter
// Single-grant arbiter over N requesters.
// Build option: STREAM_SCHED_FIXED_PRIORITY_EN selects lowest-index-wins
// and ignores the pointer input; otherwise the search starts at pointer.
// Ports:
//   eligible    : request vector
//   pointer     : first index searched (round-robin start)
//   enable      : no grant at all when low
//   grant       : one-hot grant
//   grant_idx   : index of the granted requester
//   grant_valid : a grant was issued
module stream_rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         eligible,
  input  logic [$clog2(N)-1:0] pointer,
  input  logic                 enable,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 grant_valid
);

  localparam int SW = $clog2(N);

  logic [SW-1:0] start;
  logic [SW-1:0] idx;

  // N is a power of two, so the index wraps naturally in SW bits.
  always_comb begin
`ifdef STREAM_SCHED_FIXED_PRIORITY_EN
    start = '0;
`else
    start = pointer;
`endif
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = '0;
    for (int i = 0; i < N; i++) begin
      idx = start + SW'(i);
      if (enable && !grant_valid && eligible[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
        grant[idx]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_scheduler.sv
// stream_scheduler
// Shares the main-memory stream port between CHANNELS streaming channels,
// using it only in cycles where the core instruction (mem_busy) does not.
// Build option: STREAM_SCHED_FIXED_PRIORITY_EN (lowest index wins, no
// round-robin pointer register).
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   cfg_*              : channel programming request; cfg_ready = channel idle
//   in_valid/in_value  : inbound words; in_ready = word written this cycle
//   out_valid/out_value: outbound hold registers; out_ready = consumer accept
//   mem_busy           : core owns the memory port this cycle
//   read_data          : memory result, one cycle after stream_out
//   stream_*           : request/address/data to the memory controller
//   done               : one-cycle pulse per completed transfer
module stream_scheduler
  import stream_sched_pkg::*;
#(
  parameter int MAIN_ADDR_WIDTH = 16,
  parameter int WORD_WIDTH      = 32,
  parameter int CHANNELS        = SCHED_CHANNELS
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 cfg_valid,
  input  logic [$clog2(CHANNELS)-1:0]          cfg_channel,
  input  logic                                 cfg_dir,
  input  logic [MAIN_ADDR_WIDTH-1:0]           cfg_address,
  input  logic [MAIN_ADDR_WIDTH-1:0]           cfg_length,
  output logic                                 cfg_ready,
  input  logic [CHANNELS-1:0]                  in_valid,
  input  logic [CHANNELS-1:0][WORD_WIDTH-1:0]  in_value,
  output logic [CHANNELS-1:0]                  in_ready,
  output logic [CHANNELS-1:0]                  out_valid,
  output logic [CHANNELS-1:0][WORD_WIDTH-1:0]  out_value,
  input  logic [CHANNELS-1:0]                  out_ready,
  input  logic                                 mem_busy,
  input  logic [WORD_WIDTH-1:0]                read_data,
  output logic                                 stream_in,
  output logic                                 stream_out,
  output logic [MAIN_ADDR_WIDTH-1:0]           stream_address,
  output logic [WORD_WIDTH-1:0]                stream_in_value,
  output logic [CHANNELS-1:0]                  done
);

  localparam int SW = $clog2(CHANNELS);
  localparam logic [MAIN_ADDR_WIDTH-1:0] ONE = MAIN_ADDR_WIDTH'(1);

  chan_state_t                state_q     [CHANNELS];
  chan_state_t                state_d     [CHANNELS];
  logic [MAIN_ADDR_WIDTH-1:0] addr_q      [CHANNELS];
  logic [MAIN_ADDR_WIDTH-1:0] addr_d      [CHANNELS];
  logic [MAIN_ADDR_WIDTH-1:0] remaining_q [CHANNELS];
  logic [MAIN_ADDR_WIDTH-1:0] remaining_d [CHANNELS];
  logic [WORD_WIDTH-1:0]      hold_q      [CHANNELS];
  logic [WORD_WIDTH-1:0]      hold_d      [CHANNELS];
  logic [CHANNELS-1:0]        pending_q, pending_d;
  logic [CHANNELS-1:0]        done_q, done_d;

  logic [CHANNELS-1:0]        eligible;
  logic [CHANNELS-1:0]        grant;
  logic [SW-1:0]              grant_idx;
  logic                       grant_valid;
  logic [SW-1:0]              arb_pointer;
  logic                       cfg_accept;

`ifdef STREAM_SCHED_FIXED_PRIORITY_EN
  assign arb_pointer = '0;
`else
  logic [SW-1:0] pointer_q;

  // Search restarts just after the most recent winner; frozen with no grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      pointer_q <= '0;
    end else if (grant_valid) begin
      pointer_q <= grant_idx + SW'(1);
    end
  end

  assign arb_pointer = pointer_q;
`endif

  assign cfg_ready  = (state_q[cfg_channel] == IDLE);
  assign cfg_accept = cfg_valid && cfg_ready;

  // A pending outbound channel already has its read in flight.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      eligible[c] = ((state_q[c] == RUN_IN) && in_valid[c]) ||
                    ((state_q[c] == RUN_OUT) && !pending_q[c]);
    end
  end

  stream_rr_arbiter #(.N(CHANNELS)) u_arbiter (
    .eligible    (eligible),
    .pointer     (arb_pointer),
    .enable      (!mem_busy),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // State register. Reset drops pending, so a read issued just before
  // reset is never captured.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c]     <= IDLE;
        addr_q[c]      <= '0;
        remaining_q[c] <= '0;
        hold_q[c]      <= '0;
      end
      pending_q <= '0;
      done_q    <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c]     <= state_d[c];
        addr_q[c]      <= addr_d[c];
        remaining_q[c] <= remaining_d[c];
        hold_q[c]      <= hold_d[c];
      end
      pending_q <= pending_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic. Outbound remaining is decremented at the read grant,
  // so zero in HOLD means the held word is the last one.
  always_comb begin
    done_d = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      state_d[c]     = state_q[c];
      addr_d[c]      = addr_q[c];
      remaining_d[c] = remaining_q[c];
      hold_d[c]      = pending_q[c] ? read_data : hold_q[c];
      pending_d[c]   = grant[c] && (state_q[c] == RUN_OUT);
      case (state_q[c])
        IDLE: begin
          if (cfg_accept && (cfg_channel == SW'(c))) begin
            if (cfg_length == '0) begin
              done_d[c] = 1'b1;
            end else begin
              addr_d[c]      = cfg_address;
              remaining_d[c] = cfg_length;
              state_d[c]     = (cfg_dir == DIR_IN) ? RUN_IN : RUN_OUT;
            end
          end
        end
        RUN_IN: begin
          if (grant[c]) begin
            addr_d[c]      = addr_q[c] + ONE;
            remaining_d[c] = remaining_q[c] - ONE;
            if (remaining_q[c] == ONE) begin
              state_d[c] = IDLE;
              done_d[c]  = 1'b1;
            end
          end
        end
        RUN_OUT: begin
          if (grant[c]) begin
            addr_d[c]      = addr_q[c] + ONE;
            remaining_d[c] = remaining_q[c] - ONE;
          end
          if (pending_q[c]) begin
            state_d[c] = HOLD;
          end
        end
        HOLD: begin
          if (out_ready[c]) begin
            if (remaining_q[c] == '0) begin
              state_d[c] = IDLE;
              done_d[c]  = 1'b1;
            end else begin
              state_d[c] = RUN_OUT;
            end
          end
        end
        default: state_d[c] = IDLE;
      endcase
    end
  end

  // Output logic.
  always_comb begin
    stream_in       = grant_valid && (state_q[grant_idx] == RUN_IN);
    stream_out      = grant_valid && (state_q[grant_idx] == RUN_OUT);
    stream_address  = addr_q[grant_idx];
    stream_in_value = in_value[grant_idx];
    done            = done_q;
    for (int c = 0; c < CHANNELS; c++) begin
      in_ready[c]  = grant[c] && (state_q[c] == RUN_IN);
      out_valid[c] = (state_q[c] == HOLD);
      out_value[c] = hold_q[c];
    end
  end

endmodule

// File: tb/tb_stream_scheduler.sv
`timescale 1ns/1ps
// tb_stream_scheduler
// Directed and randomized stimulus against a transaction-level reference
// model of the scheduler (per-channel words left, next address, read in
// flight, held word, rotating search start).
module tb_stream_scheduler;
  import stream_sched_pkg::*;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int WW = 32;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 cfg_valid;
  chan_sel_t            cfg_channel;
  logic                 cfg_dir;
  logic [AW-1:0]        cfg_address;
  logic [AW-1:0]        cfg_length;
  logic                 cfg_ready;
  logic [N-1:0]         in_valid;
  logic [N-1:0][WW-1:0] in_value;
  logic [N-1:0]         in_ready;
  logic [N-1:0]         out_valid;
  logic [N-1:0][WW-1:0] out_value;
  logic [N-1:0]         out_ready;
  logic                 mem_busy;
  logic [WW-1:0]        read_data;
  logic                 stream_in;
  logic                 stream_out;
  logic [AW-1:0]        stream_address;
  logic [WW-1:0]        stream_in_value;
  logic [N-1:0]         done;

  always #5 clk = ~clk;

  stream_scheduler #(.MAIN_ADDR_WIDTH(AW), .WORD_WIDTH(WW), .CHANNELS(N)) dut (
    .clk             (clk),
    .reset           (reset),
    .cfg_valid       (cfg_valid),
    .cfg_channel     (cfg_channel),
    .cfg_dir         (cfg_dir),
    .cfg_address     (cfg_address),
    .cfg_length      (cfg_length),
    .cfg_ready       (cfg_ready),
    .in_valid        (in_valid),
    .in_value        (in_value),
    .in_ready        (in_ready),
    .out_valid       (out_valid),
    .out_value       (out_value),
    .out_ready       (out_ready),
    .mem_busy        (mem_busy),
    .read_data       (read_data),
    .stream_in       (stream_in),
    .stream_out      (stream_out),
    .stream_address  (stream_address),
    .stream_in_value (stream_in_value),
    .done            (done)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model state, in transfer terms.
  bit            m_busy  [N];
  bit            m_dir   [N];
  int unsigned   m_next  [N];
  int            m_left  [N];
  bit            m_pend  [N];
  bit            m_hvalid[N];
  logic [WW-1:0] m_hword [N];
  logic [N-1:0]  m_done;
  int            m_ptr;

  task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int c = 0; c < N; c++) begin
      m_busy[c]   = 1'b0;
      m_dir[c]    = 1'b0;
      m_next[c]   = 0;
      m_left[c]   = 0;
      m_pend[c]   = 1'b0;
      m_hvalid[c] = 1'b0;
      m_hword[c]  = '0;
    end
    m_done = '0;
    m_ptr  = 0;
  endtask

  function automatic bit modelEligible(int c);
    if (!m_busy[c] || m_left[c] == 0) return 1'b0;
    if (m_dir[c] == 1'b0) return in_valid[c];
    return !m_pend[c] && !m_hvalid[c];
  endfunction

  function automatic int modelWinner();
    int start;
`ifdef STREAM_SCHED_FIXED_PRIORITY_EN
    start = 0;
`else
    start = m_ptr;
`endif
    if (mem_busy) return -1;
    for (int i = 0; i < N; i++) begin
      if (modelEligible((start + i) % N)) return (start + i) % N;
    end
    return -1;
  endfunction

  task automatic checkOutput();
    int           w;
    bit           g_in, g_out;
    logic [N-1:0] exp_rdy, exp_ov;
    w       = modelWinner();
    g_in    = (w >= 0) && (m_dir[w] == 1'b0);
    g_out   = (w >= 0) && (m_dir[w] == 1'b1);
    exp_rdy = '0;
    exp_ov  = '0;
    if (g_in) exp_rdy[w] = 1'b1;
    for (int c = 0; c < N; c++) exp_ov[c] = m_hvalid[c];
    checkEq("stream_in", stream_in, g_in);
    checkEq("stream_out", stream_out, g_out);
    checkEq("in_ready", in_ready, exp_rdy);
    if (w >= 0) checkEq($sformatf("stream_address ch%0d", w), stream_address, m_next[w] & 32'hFFFF);
    if (g_in) checkEq($sformatf("stream_in_value ch%0d", w), stream_in_value, in_value[w]);
    checkEq("out_valid", out_valid, exp_ov);
    for (int c = 0; c < N; c++) begin
      if (m_hvalid[c]) checkEq($sformatf("out_value ch%0d", c), out_value[c], m_hword[c]);
    end
    checkEq("done", done, m_done);
    checkEq($sformatf("cfg_ready ch%0d", cfg_channel), cfg_ready, !m_busy[cfg_channel]);
  endtask

  task automatic modelUpdate();
    int           w;
    bit           acc;
    logic [N-1:0] nd;
    w   = modelWinner();
    acc = cfg_valid && !m_busy[cfg_channel];
    nd  = '0;
    for (int c = 0; c < N; c++) begin
      if (m_hvalid[c] && out_ready[c]) begin
        m_hvalid[c] = 1'b0;
        if (m_left[c] == 0) begin
          m_busy[c] = 1'b0;
          nd[c]     = 1'b1;
        end
      end
      if (m_pend[c]) begin
        m_hword[c]  = read_data;
        m_hvalid[c] = 1'b1;
        m_pend[c]   = 1'b0;
      end
    end
    if (w >= 0) begin
      m_next[w] = (m_next[w] + 1) & 32'hFFFF;
      m_left[w] = m_left[w] - 1;
      if (m_dir[w] == 1'b0) begin
        if (m_left[w] == 0) begin
          m_busy[w] = 1'b0;
          nd[w]     = 1'b1;
        end
      end else begin
        m_pend[w] = 1'b1;
      end
      m_ptr = (w + 1) % N;
    end
    if (acc) begin
      if (cfg_length == '0) begin
        nd[cfg_channel] = 1'b1;
      end else begin
        m_busy[cfg_channel] = 1'b1;
        m_dir[cfg_channel]  = cfg_dir;
        m_next[cfg_channel] = 32'(cfg_address);
        m_left[cfg_channel] = int'(cfg_length);
      end
    end
    m_done = nd;
  endtask

  // Drives one cycle of inputs, checks outputs mid-cycle, then advances
  // the model and the clock together.
  task automatic applyStimulus(input bit cv, input int ch, input bit dir, input int addr,
                               input int len, input logic [N-1:0] iv,
                               input logic [N-1:0] ordy, input bit busy);
    cfg_valid   = cv;
    cfg_channel = chan_sel_t'(ch);
    cfg_dir     = dir;
    cfg_address = AW'(addr);
    cfg_length  = AW'(len);
    in_valid    = iv;
    out_ready   = ordy;
    mem_busy    = busy;
    for (int c = 0; c < N; c++) in_value[c] = $urandom;
    read_data   = {16'hA5A5, cyc[15:0]};
    #4;
    checkOutput();
    modelUpdate();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic runIdle(input int n, input logic [N-1:0] iv, input logic [N-1:0] ordy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 1'b0, 0, 0, iv, ordy, 1'b0);
  endtask

  task automatic doReset();
    reset     = 1'b1;
    cfg_valid = 1'b0;
    in_valid  = '0;
    out_ready = '0;
    mem_busy  = 1'b0;
    @(posedge clk);
    #1;
    modelReset();
    reset = 1'b0;
  endtask

  initial begin
    cfg_channel = '0;
    cfg_dir     = 1'b0;
    cfg_address = '0;
    cfg_length  = '0;
    in_value    = '0;
    read_data   = '0;
    doReset();
    runIdle(2, '0, '0);

    $display("[TB] inbound ch0 0x0100 len 3");
    applyStimulus(1'b1, 0, DIR_IN, 'h0100, 3, 4'b0001, '0, 1'b0);
    runIdle(5, 4'b0001, '0);

    $display("[TB] outbound ch1 0x0200 len 2");
    applyStimulus(1'b1, 1, DIR_OUT, 'h0200, 2, '0, 4'b0010, 1'b0);
    runIdle(10, '0, 4'b0010);

    $display("[TB] four inbound channels, rotation and mem_busy");
    for (int c = 0; c < N; c++) applyStimulus(1'b1, c, DIR_IN, 'h1000 + 'h100 * c, 5, '0, '0, 1'b0);
    runIdle(6, 4'hF, '0);
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 0, 1'b0, 0, 0, 4'hF, '0, (i % 2) == 0);
    runIdle(10, 4'hF, '0);

    $display("[TB] address wrap");
    applyStimulus(1'b1, 3, DIR_IN, 'hFFFF, 2, 4'b1000, '0, 1'b0);
    runIdle(4, 4'b1000, '0);

    $display("[TB] zero length and busy-channel config");
    applyStimulus(1'b1, 2, DIR_IN, 'h0050, 0, '0, '0, 1'b0);
    applyStimulus(1'b0, 2, DIR_IN, 0, 0, '0, '0, 1'b0);
    applyStimulus(1'b1, 0, DIR_IN, 'h0400, 4, '0, '0, 1'b0);
    applyStimulus(1'b1, 0, DIR_OUT, 'h0999, 1, '0, '0, 1'b0);
    runIdle(6, 4'b0001, '0);

    $display("[TB] reset while ch2 holds a word");
    applyStimulus(1'b1, 2, DIR_OUT, 'h0300, 3, '0, '0, 1'b0);
    runIdle(4, '0, '0);
    doReset();
    for (int c = 0; c < N; c++) applyStimulus(1'b0, c, 1'b0, 0, 0, '0, '0, 1'b0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      if (i == 200) doReset();
      applyStimulus(($urandom % 4) == 0, int'($urandom % N), 1'($urandom),
                    int'($urandom % 65536), int'($urandom_range(0, 4)),
                    N'($urandom), N'($urandom), ($urandom % 4) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
